// File: rtl/sma_scheduler_if.sv
// Handshake bundle between the requester feeds / result consumer and the
// moving-average scheduler. The master drives samples, clears and result
// acceptance; the slave (the scheduler) drives grants and results.
interface sma_scheduler_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            req_valid_i;
    logic [NUM_CH*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_CH-1:0]            req_ready_o;
    logic                         clear_i;
    logic [CW-1:0]                clear_ch_i;
    logic                         avg_valid_o;
    logic                         avg_ready_i;
    logic [CW-1:0]                avg_ch_o;
    logic [DATA_WIDTH-1:0]        avg_data_o;
    logic                         avg_full_o;

    modport master (
        output req_valid_i, req_data_i, clear_i, clear_ch_i, avg_ready_i,
        input  req_ready_o, avg_valid_o, avg_ch_o, avg_data_o, avg_full_o
    );

    modport slave (
        input  req_valid_i, req_data_i, clear_i, clear_ch_i, avg_ready_i,
        output req_ready_o, avg_valid_o, avg_ch_o, avg_data_o, avg_full_o
    );
endinterface

// File: rtl/sma_scheduler.sv
// Round-robin scheduler over NUM_CH price feeds. Each granted sample updates
// that channel's sliding window and produces a registered moving average one
// cycle later. A result slot with valid/ready backpressure gates the grants.
module sma_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int WINDOW_SIZE = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    sma_scheduler_if.slave    bus
);
    localparam int CW = $clog2(NUM_CH);
    localparam int LW = $clog2(WINDOW_SIZE);
    localparam int SW = DATA_WIDTH + LW;
    localparam logic [LW:0] FULL_CNT = (LW+1)'(WINDOW_SIZE);

    // Per-channel window state
    logic [DATA_WIDTH-1:0] ring_r  [NUM_CH][WINDOW_SIZE];
    logic [LW-1:0]         wptr_r  [NUM_CH];
    logic [LW:0]           count_r [NUM_CH];
    logic [SW-1:0]         sum_r   [NUM_CH];
    logic [CW-1:0]         rr_ptr_r;

    // Registered result slot
    logic                  avg_valid_r;
    logic [CW-1:0]         avg_ch_r;
    logic [DATA_WIDTH-1:0] avg_data_r;
    logic                  avg_full_r;

    // Arbitration and datapath
    logic                  slot_free_s;
    logic                  xfer_s;
    logic [CW-1:0]         gch_s;
    logic [NUM_CH-1:0]     grant_s;
    logic [DATA_WIDTH-1:0] new_data_s;
    logic [DATA_WIDTH-1:0] oldest_s;
    logic                  was_full_s;
    logic [SW-1:0]         sum_next_s;
    logic [LW:0]           count_next_s;
    logic                  full_next_s;
    logic [DATA_WIDTH-1:0] avg_next_s;

    // Channel index k positions after base, wrapping at NUM_CH
    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end else begin
            s = s;
        end
        return CW'(s);
    endfunction

    // Round-robin search from rr_ptr; a channel being cleared cannot win
    always_comb begin
        slot_free_s = !avg_valid_r || bus.avg_ready_i;
        xfer_s      = 1'b0;
        gch_s       = '0;
        grant_s     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!xfer_s && slot_free_s && reset_i &&
                bus.req_valid_i[rr_idx(rr_ptr_r, k)] &&
                !(bus.clear_i && (bus.clear_ch_i == rr_idx(rr_ptr_r, k)))) begin
                xfer_s = 1'b1;
                gch_s  = rr_idx(rr_ptr_r, k);
            end else begin
                xfer_s = xfer_s;
            end
        end
        if (xfer_s) begin
            grant_s[gch_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Window update and average for the granted channel
    always_comb begin
        new_data_s   = bus.req_data_i[int'(gch_s)*DATA_WIDTH +: DATA_WIDTH];
        was_full_s   = (count_r[gch_s] == FULL_CNT);
        oldest_s     = '0;
        count_next_s = FULL_CNT;
        avg_next_s   = '0;
        if (was_full_s) begin
            oldest_s     = ring_r[gch_s][wptr_r[gch_s]];
            count_next_s = FULL_CNT;
        end else begin
            oldest_s     = '0;
            count_next_s = count_r[gch_s] + (LW+1)'(1);
        end
        // Modular arithmetic is exact: the final sum always fits in SW bits
        sum_next_s  = sum_r[gch_s] + SW'(new_data_s) - SW'(oldest_s);
        full_next_s = (count_next_s == FULL_CNT);
        if (full_next_s) begin
            avg_next_s = sum_next_s[SW-1:LW];
        end else begin
            avg_next_s = DATA_WIDTH'(sum_next_s / SW'(count_next_s));
        end
    end

    // Channel state, round-robin pointer and result slot
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int w = 0; w < WINDOW_SIZE; w++) begin
                    ring_r[c][w] <= '0;
                end
                wptr_r[c]  <= '0;
                count_r[c] <= '0;
                sum_r[c]   <= '0;
            end
            rr_ptr_r    <= '0;
            avg_valid_r <= 1'b0;
            avg_ch_r    <= '0;
            avg_data_r  <= '0;
            avg_full_r  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.clear_i && (bus.clear_ch_i == CW'(c))) begin
                    for (int w = 0; w < WINDOW_SIZE; w++) begin
                        ring_r[c][w] <= '0;
                    end
                    wptr_r[c]  <= '0;
                    count_r[c] <= '0;
                    sum_r[c]   <= '0;
                end else if (xfer_s && (gch_s == CW'(c))) begin
                    ring_r[c][wptr_r[c]] <= new_data_s;
                    wptr_r[c]            <= wptr_r[c] + LW'(1);
                    sum_r[c]             <= sum_next_s;
                    count_r[c]           <= count_next_s;
                end
            end
            if (xfer_s) begin
                rr_ptr_r    <= (gch_s == CW'(NUM_CH-1)) ? '0 : gch_s + CW'(1);
                avg_valid_r <= 1'b1;
                avg_ch_r    <= gch_s;
                avg_data_r  <= avg_next_s;
                avg_full_r  <= full_next_s;
            end else if (bus.avg_ready_i) begin
                avg_valid_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o = grant_s;
    assign bus.avg_valid_o = avg_valid_r;
    assign bus.avg_ch_o    = avg_ch_r;
    assign bus.avg_data_o  = avg_data_r;
    assign bus.avg_full_o  = avg_full_r;
endmodule

// File: doc/sma_scheduler.md
SMA_SCHEDULER -- requirements
Module: sma_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requester channels (symbol feeds), 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: price sample width, unsigned.
REQ-003 SHALL have parameter WINDOW_SIZE, default 4: averaging window depth, a power of 2, 2..16.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid_i, input, NUM_CH: per-channel sample valid.
REQ-007 SHALL have port req_data_i, input, NUM_CH*DATA_WIDTH: per-channel sample; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready_o, output, NUM_CH: per-channel accept, one-hot or zero.
REQ-009 SHALL have port clear_i, input, 1: window clear request.
REQ-010 SHALL have port clear_ch_i, input, clog2(NUM_CH): channel that clear_i targets.
REQ-011 SHALL have port avg_valid_o, output, 1: result valid.
REQ-012 SHALL have port avg_ready_i, input, 1: downstream accept.
REQ-013 SHALL have port avg_ch_o, output, clog2(NUM_CH): channel the result belongs to.
REQ-014 SHALL have port avg_data_o, output, DATA_WIDTH: moving average.
REQ-015 SHALL have port avg_full_o, output, 1: the window was full when the result was computed.

Function
REQ-016 SHALL keep per-channel state: a WINDOW_SIZE-entry sample ring, a write pointer, a fill count (0..WINDOW_SIZE, saturating), and a running sum of DATA_WIDTH+log2(WINDOW_SIZE) bits.
REQ-017 SHALL define slot_free = !avg_valid_o || avg_ready_i.
REQ-018 SHALL arbitrate round-robin: when slot_free is high, grant the first channel c with req_valid_i[c] high, excluding the channel being cleared, searching from rr_ptr upward modulo NUM_CH.
REQ-019 SHALL drive req_ready_o combinationally as the one-hot grant; req_ready_o is all-zero when slot_free is low.
REQ-020 SHALL treat a transfer as req_valid_i[c] && req_ready_o[c], and after each transfer set rr_ptr to (c+1) mod NUM_CH; rr_ptr is unchanged in cycles without a transfer.
REQ-021 SHALL, on a transfer, in the same edge: write the sample at the write pointer, advance the pointer modulo WINDOW_SIZE, compute sum' = sum + new - oldest (oldest reads 0 while count < WINDOW_SIZE), and increment count saturating at WINDOW_SIZE.
REQ-022 SHALL register the result at that same edge, giving a latency of 1 cycle: avg_valid_o=1, avg_ch_o=c, avg_full_o=(count'==WINDOW_SIZE).
REQ-023 SHALL set avg_data_o = sum' >> log2(WINDOW_SIZE) when the window is full, else sum' / count' with truncating integer division.
REQ-024 SHALL hold avg_valid_o, avg_ch_o, avg_data_o and avg_full_o stable while avg_valid_o && !avg_ready_i.
REQ-025 SHALL clear avg_valid_o after an output handshake when no new transfer occurs in that cycle; a handshake and a new transfer in the same cycle SHALL replace the result without a bubble.
REQ-026 SHALL, on clear_i, zero the target channel's ring, sum, count and write pointer at the next edge.
REQ-027 SHALL give clear priority over a same-cycle request on the same channel: that channel is not granted, its sample is not consumed, and other channels arbitrate normally.
REQ-028 SHALL leave an already-registered result for the cleared channel unaffected.
REQ-029 SHALL not overflow the running sum for any input sequence, since its width covers WINDOW_SIZE maximal samples.

Reset
REQ-030 SHALL, while reset_i=0 and independent of clk_i, force avg_valid_o=0, avg_ch_o=0, avg_data_o=0, avg_full_o=0, rr_ptr=0, and all rings, sums, counts and pointers to 0.
REQ-031 SHALL force req_ready_o to zero while reset_i=0.
REQ-032 SHALL, when reset_i asserts mid-stream, discard any pending output; the first transfer after release is treated as a first sample.

Verification
REQ-033 SHALL cover: channel 0 only, samples 10,20,30,40,50, avg_ready_i=1 -> avg_data_o = 10,15,20,25,35; avg_full_o = 0,0,0,1,1; each result 1 cycle after its transfer.
REQ-034 SHALL cover: all 4 channels valid continuously from reset -> grants in order 0,1,2,3,0,...; exactly one req_ready_o bit high per cycle.
REQ-035 SHALL cover: avg_ready_i=0 for 3 cycles with a result pending -> req_ready_o=0 and the outputs stable; on release the next grant follows in the same cycle.
REQ-036 SHALL cover: clear_i with clear_ch_i=2 and req_valid_i[2]=1 in the same cycle -> no grant to channel 2; its next sample 8 yields avg_data_o=8, avg_full_o=0.
REQ-037 SHALL cover: channel 1 fed 2^64-1 four times -> avg_data_o=2^64-1 with no wrap.
REQ-038 SHALL cover: reset_i pulsed low asynchronously mid-window -> outputs 0 immediately; the next sample 100 yields avg_data_o=100.
